// File: rtl/bt_uart_pkg.sv
// Shared definitions for the Bluetooth UART transmit slice.
// Optional feature macro: BT_UART_CR_TERMINATE_EN (stop the frame after the first CR byte).
package bt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    FINISH
  } bt_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int FRAME_BYTES_DEFAULT  = 18;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/bt_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, restartable.
module bt_baud_tick
  import bt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Count 0..CLKS_PER_BIT-1, wrapping at every bit boundary; restart aligns to a new frame.
  always_ff @(posedge clk) begin
    if (reset || restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/bluetooth_uart_tx.sv
// 8N1 serial transmitter for one latched Bluetooth command frame.
// Optional feature macro: BT_UART_CR_TERMINATE_EN (frame ends after the first CR byte).
module bluetooth_uart_tx
  import bt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FRAME_BYTES  = FRAME_BYTES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8*FRAME_BYTES-1:0] frame_data,
  input  logic                     start,
  output logic                     tx,
  output logic                     busy,
  output logic                     done
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);

  bt_state_t                state;
  logic [8*FRAME_BYTES-1:0] frame_buf;
  logic [4:0]               byte_idx;
  logic [2:0]               bit_idx;
  logic [7:0]               cur_byte;
  logic                     accept;
  logic                     last_byte;
  logic                     bit_tick;

  assign cur_byte = frame_buf[{byte_idx, 3'b000} +: 8];
  assign accept   = start && ((state == IDLE) || (state == FINISH));

`ifdef BT_UART_CR_TERMINATE_EN
  assign last_byte = (byte_idx == LAST_IDX) || (cur_byte == ASCII_CR);
`else
  assign last_byte = (byte_idx == LAST_IDX);
`endif

  bt_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .tick   (bit_tick)
  );

  // Frame FSM with registered tx/busy/done; FINISH accepts a new start just like IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      frame_buf <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            frame_buf <= frame_data;
            byte_idx  <= '0;
            bit_idx   <= '0;
            state     <= START_BIT;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        end
        START_BIT: begin
          if (bit_tick) begin
            state   <= DATA_BITS;
            bit_idx <= '0;
            tx      <= cur_byte[0];
          end
        end
        DATA_BITS: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
              state <= STOP_BIT;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end
        end
        STOP_BIT: begin
          if (bit_tick) begin
            if (last_byte) begin
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 5'd1;
              state    <= START_BIT;
              tx       <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bluetooth_uart_tx.md
# bluetooth_uart_tx

Serial transmit stage placed directly downstream of the Bluetooth command encoder. Latches one 144-bit encoded command frame (18 ASCII bytes, byte 0 in bits [7:0]) on a start pulse. Sends it byte by byte as 8N1 asynchronous serial on the UART line to the BLE module. Reports completion with a one-cycle `done` pulse.

## Interface

Parameters:
- CLKS_PER_BIT, 434: clock cycles per serial bit (50 MHz / 115200); must be >= 2
- FRAME_BYTES, 18: bytes in one frame; frame width = 8*FRAME_BYTES

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- frame_data  in  144  encoded command; byte k at [8k+7:8k]
- start  in  1  request to send frame_data; sampled only when busy=0
- tx  out  1  UART serial line; idle high
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last stop bit has finished

## Operation

- States: IDLE, START_BIT, DATA_BITS, STOP_BIT, FINISH.
- IDLE: tx=1, busy=0. When start=1, latch frame_data into the internal frame buffer, clear byte index and bit index, and go to START_BIT.
- START_BIT: tx=0 for CLKS_PER_BIT cycles, then DATA_BITS.
- DATA_BITS: drive 8 bits of the current byte LSB first, each for CLKS_PER_BIT cycles, then STOP_BIT.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then, if the current byte is the last byte, go to FINISH. Otherwise increment the byte index and go to START_BIT with no idle gap.
- Last byte: byte index = FRAME_BYTES-1. Optionally also the first CR byte (see Configuration).
- FINISH: done=1 and busy=0 for one cycle, then IDLE. A start asserted in this cycle is accepted exactly as in IDLE.
- start is ignored while busy=1. Changes on frame_data after the latch do not affect the transfer.
- Baud counter counts 0..CLKS_PER_BIT-1 with width $clog2(CLKS_PER_BIT). It reloads to 0 at every bit boundary. Byte index is 5 bits and saturates at the last byte.
- Reset at any point, including mid-bit: the next edge gives tx=1, busy=0, done=0, state IDLE and cleared counters. No done pulse is produced for an aborted frame.

## Timing

- Reset values: tx=1, busy=0, done=0.
- tx is registered. If start is sampled at edge 0, tx=0 and busy=1 from edge 1.
- Each byte takes 10*CLKS_PER_BIT cycles: 1 start bit, 8 data bits, 1 stop bit.
- For an N-byte transfer, done is high in the cycle starting at edge 1 + N*10*CLKS_PER_BIT.
- busy falls in the same cycle that done rises.

## Configuration

- BT_UART_CR_TERMINATE_EN defined: the transfer ends after the first byte equal to 0x0D (CR), CR included. Bytes after it are not sent.
- BT_UART_CR_TERMINATE_EN undefined: all FRAME_BYTES bytes are always sent, whatever their contents.

## Structure

- Shared package bt_uart_pkg:
  - state enum
  - ASCII_CR = 8'h0D
  - default FRAME_BYTES and CLKS_PER_BIT constants
- Sub-module bt_baud_tick:
  - counter that emits a one-cycle tick every CLKS_PER_BIT cycles
  - cleared by reset and by a restart input driven on start acceptance

## Test plan

All scenarios use CLKS_PER_BIT=4 unless stated.
- Reset held 3 cycles, then released -> tx=1, busy=0, done=0; no activity without start.
- Frame "AT+BLEUARTTX=1234\r", start at edge 0, macro defined -> byte 0 (0x41) appears on tx as 0,1,0,0,0,0,0,1,0,1. 18 bytes are sent. done pulses at edge 721 for exactly one cycle.
- Frame "AT+BLEUARTRX\r" followed by five 0x00 bytes, with the macro defined -> 13 bytes sent, done at edge 521. Same frame without the macro -> 18 bytes sent, the last five are 0x00, done at edge 721.
- start pulsed again at edge 100 and frame_data changed mid-transfer -> ignored; the serial output matches the originally latched frame.
- reset asserted during DATA_BITS of byte 3 -> tx=1 and busy=0 at the next edge; no done pulse. A following start sends the whole frame from byte 0.
- start held high in the FINISH cycle -> the second frame begins immediately: tx=0 at the next edge, busy high with no idle cycle.
